// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem.
// Holds the metadata that travels with each accepted x_mem request so the
// memory result can be routed back to the right destination register.
package fpu_ss_pkg;

  typedef struct packed {
    logic [4:0] rd;       // destination register of the load/store
    logic       we;       // result writes back to the register file
    logic [3:0] core_id;  // issuing core
    logic [3:0] id;       // offload instruction id
  } mem_metadata_t;

endpackage

// File: rtl/fpu_ss_mem_buffer.sv
// Purpose: FIFO of outstanding x_mem request metadata, popped on memory result.
// Latency: 1 cycle push-to-pop (0 cycles when FALL_THROUGH=1 and empty).
// Backpressure: push_ready_o low when full or flushing; a pop never frees space same cycle.
module fpu_ss_mem_buffer
  import fpu_ss_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter bit FALL_THROUGH = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  mem_metadata_t              push_data_i,
  output logic                       pop_valid_o,
  input  logic                       pop_ready_i,
  output mem_metadata_t              pop_data_o,
  output logic [$clog2(DEPTH):0]     usage_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mem_metadata_t    mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] usage_q;
  logic             underflow_q;

  logic push_hs;
  logic pop_hs;
  logic store;
  logic take;

  assign full_o       = (usage_q == CNT_W'(DEPTH));
  assign empty_o      = (usage_q == '0);
  assign usage_o      = usage_q;
  assign underflow_o  = underflow_q;

  // A full buffer refuses pushes even if a pop frees a slot this cycle.
  assign push_ready_o = ~full_o & ~flush_i;

  // When empty, fall-through exposes the incoming entry directly.
  assign pop_valid_o  = ~flush_i & (~empty_o | (FALL_THROUGH & push_valid_i));
  assign pop_data_o   = empty_o ? push_data_i : mem_q[rd_ptr_q];

  assign push_hs = push_valid_i & push_ready_o;
  assign pop_hs  = pop_valid_o & pop_ready_i;

  // A push consumed in the same cycle through the bypass is never stored.
  assign store   = push_hs & ~(empty_o & pop_hs);
  assign take    = pop_hs & ~empty_o;

  // Storage array: written on stored pushes only, never reset.
  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; flush outranks any handshake in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (store) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (take) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({store, take})
        2'b10:   usage_q <= usage_q + CNT_W'(1);
        2'b01:   usage_q <= usage_q - CNT_W'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  // One-cycle flag for a consumer asking for a result that is not there.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= pop_ready_i & ~pop_valid_o;
    end
  end

endmodule
